// File: rtl/mailbox_pkg.sv
// Shared mailbox types: per-beat tag carried alongside Wishbone traffic,
// plus uplink arbiter defaults and FSM encoding.
package mailbox_pkg;

  typedef struct packed {
    logic [5:0] chan;
    logic       prio;
    logic       eop;
  } mailbox_tag_t;

  localparam int unsigned MBX_ARB_AGE_LIMIT_DEFAULT = 8;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

endpackage

// File: rtl/mailbox_rr_pick.sv
// Masked round-robin one-hot picker: first request at or above rr_ptr,
// otherwise wraps to the lowest request.
module mailbox_rr_pick #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic [N_REQ-1:0]         pick
);

  logic [N_REQ-1:0] masked;
  logic [N_REQ-1:0] src;
  logic             found;

  always_comb begin
    masked = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      masked[i] = req[i] && (i >= 32'(rr_ptr));
    end
    src   = (|masked) ? masked : req;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (src[i] && !found) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mailbox_uplink_arb.sv
// N-to-1 Wishbone uplink arbiter with packet locking, priority classes,
// starvation aging and a grant watchdog.
module mailbox_uplink_arb
  import mailbox_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned AGE_LIMIT    = MBX_ARB_AGE_LIMIT_DEFAULT,
  parameter int unsigned LOCK_TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        s_wb_cyc,
  input  logic [N_REQ-1:0]        s_wb_stb,
  input  logic [N_REQ-1:0]        s_wb_we,
  input  logic [N_REQ-1:0][15:0]  s_wb_adr,
  input  logic [N_REQ-1:0][31:0]  s_wb_dat,
  input  logic [N_REQ-1:0][3:0]   s_wb_sel,
  input  mailbox_tag_t [N_REQ-1:0] s_tag,
  output logic [N_REQ-1:0]        s_wb_ack,
  output logic                    m_wb_cyc,
  output logic                    m_wb_stb,
  output logic                    m_wb_we,
  output logic [15:0]             m_wb_adr,
  output logic [31:0]             m_wb_dat,
  output logic [3:0]              m_wb_sel,
  output mailbox_tag_t            m_tag,
  input  logic                    m_wb_ack,
  output logic [N_REQ-1:0]        grant_oh,
  output logic                    lock_err
);

  localparam int unsigned PW = $clog2(N_REQ);
  localparam int unsigned AW = $clog2(AGE_LIMIT + 1);
  localparam int unsigned WW = $clog2(LOCK_TIMEOUT);

  arb_state_t state, state_nxt;

  logic [N_REQ-1:0]         req, aged_req, prio_req;
  logic [N_REQ-1:0]         pick_aged, pick_prio, pick_norm, winner;
  logic [N_REQ-1:0]         grant_q;
  logic [PW-1:0]            owner, rr_ptr, winner_idx, next_ptr;
  logic [N_REQ-1:0][AW-1:0] age;
  logic [WW-1:0]            wd;
  logic                     lock_err_q;
  logic                     arb_fire, pkt_done, timeout, owner_cyc;

  assign req = s_wb_cyc & s_wb_stb;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      aged_req[i] = req[i] && (age[i] == AW'(AGE_LIMIT));
      prio_req[i] = req[i] && s_tag[i].prio;
    end
  end

  mailbox_rr_pick #(.N_REQ(N_REQ)) u_pick_aged (.req(aged_req), .rr_ptr(rr_ptr), .pick(pick_aged));
  mailbox_rr_pick #(.N_REQ(N_REQ)) u_pick_prio (.req(prio_req), .rr_ptr(rr_ptr), .pick(pick_prio));
  mailbox_rr_pick #(.N_REQ(N_REQ)) u_pick_norm (.req(req),      .rr_ptr(rr_ptr), .pick(pick_norm));

  always_comb begin
    winner     = (|aged_req) ? pick_aged : ((|prio_req) ? pick_prio : pick_norm);
    winner_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (winner[i]) winner_idx = PW'(i);
    end
    next_ptr = (owner == PW'(N_REQ - 1)) ? '0 : owner + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  // Owner dropping cyc beats ack; ack beats the watchdog.
  always_comb begin
    state_nxt = state;
    arb_fire  = 1'b0;
    pkt_done  = 1'b0;
    timeout   = 1'b0;
    owner_cyc = s_wb_cyc[owner];
    case (state)
      ARB_IDLE: begin
        if (|req) begin
          arb_fire  = 1'b1;
          state_nxt = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (!owner_cyc) begin
          pkt_done = 1'b1;
        end else if (m_wb_ack) begin
          pkt_done = s_tag[owner].eop;
        end else if (wd == WW'(LOCK_TIMEOUT - 1)) begin
          pkt_done = 1'b1;
          timeout  = 1'b1;
        end
        if (pkt_done) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    grant_oh = grant_q;
    lock_err = lock_err_q;
    s_wb_ack = '0;
    m_wb_cyc = 1'b0;
    m_wb_stb = 1'b0;
    m_wb_we  = 1'b0;
    m_wb_adr = '0;
    m_wb_dat = '0;
    m_wb_sel = '0;
    m_tag    = '0;
    if (state == ARB_LOCKED) begin
      m_wb_cyc        = s_wb_cyc[owner];
      m_wb_stb        = s_wb_stb[owner];
      m_wb_we         = s_wb_we[owner];
      m_wb_adr        = s_wb_adr[owner];
      m_wb_dat        = s_wb_dat[owner];
      m_wb_sel        = s_wb_sel[owner];
      m_tag           = s_tag[owner];
      s_wb_ack[owner] = m_wb_ack && s_wb_cyc[owner];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q    <= '0;
      owner      <= '0;
      rr_ptr     <= '0;
      wd         <= '0;
      lock_err_q <= 1'b0;
      age        <= '0;
    end else begin
      lock_err_q <= timeout;
      if (arb_fire) begin
        grant_q <= winner;
        owner   <= winner_idx;
        wd      <= '0;
      end else if (pkt_done) begin
        grant_q <= '0;
        rr_ptr  <= next_ptr;
      end else if (state == ARB_LOCKED) begin
        wd <= m_wb_ack ? '0 : wd + WW'(1);
      end
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!req[i]) begin
          age[i] <= '0;
        end else if (arb_fire) begin
          if (winner[i])                       age[i] <= '0;
          else if (age[i] != AW'(AGE_LIMIT))   age[i] <= age[i] + AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mailbox_uplink_arb.sv
// Self-checking bench for mailbox_uplink_arb: directed scenarios plus
// randomized traffic against a behavioural arbitration model.
module tb_mailbox_uplink_arb;
  import mailbox_pkg::*;

  localparam int N  = 4;
  localparam int AL = 2;
  localparam int LT = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N-1:0]           s_wb_cyc, s_wb_stb, s_wb_we, s_wb_ack;
  logic [N-1:0][15:0]     s_wb_adr;
  logic [N-1:0][31:0]     s_wb_dat;
  logic [N-1:0][3:0]      s_wb_sel;
  mailbox_tag_t [N-1:0]   s_tag;
  logic                   m_wb_cyc, m_wb_stb, m_wb_we, m_wb_ack;
  logic [15:0]            m_wb_adr;
  logic [31:0]            m_wb_dat;
  logic [3:0]             m_wb_sel;
  mailbox_tag_t           m_tag;
  logic [N-1:0]           grant_oh;
  logic                   lock_err;

  always #5 clk = ~clk;

  mailbox_uplink_arb #(.N_REQ(N), .AGE_LIMIT(AL), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_wb_cyc(s_wb_cyc), .s_wb_stb(s_wb_stb), .s_wb_we(s_wb_we),
    .s_wb_adr(s_wb_adr), .s_wb_dat(s_wb_dat), .s_wb_sel(s_wb_sel),
    .s_tag(s_tag), .s_wb_ack(s_wb_ack),
    .m_wb_cyc(m_wb_cyc), .m_wb_stb(m_wb_stb), .m_wb_we(m_wb_we),
    .m_wb_adr(m_wb_adr), .m_wb_dat(m_wb_dat), .m_wb_sel(m_wb_sel),
    .m_tag(m_tag), .m_wb_ack(m_wb_ack),
    .grant_oh(grant_oh), .lock_err(lock_err)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model: owner index (-1 idle), rr pointer, lost-round ages.
  int mdl_owner;
  int mdl_rr;
  int mdl_age [N];
  int mdl_wd;
  bit mdl_lerr;

  task automatic model_reset();
    mdl_owner = -1;
    mdl_rr    = 0;
    mdl_wd    = 0;
    mdl_lerr  = 0;
    for (int i = 0; i < N; i++) mdl_age[i] = 0;
  endtask

  function automatic bit is_req(int i);
    return s_wb_cyc[i] && s_wb_stb[i];
  endfunction

  function automatic int pick_winner();
    for (int cls = 0; cls < 3; cls++) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        bit cand;
        idx  = (mdl_rr + k) % N;
        cand = is_req(idx) && ((cls == 0) ? (mdl_age[idx] == AL) :
                               (cls == 1) ? (s_tag[idx].prio == 1'b1) : 1'b1);
        if (cand) return idx;
      end
    end
    return -1;
  endfunction

  task automatic model_step();
    bit nl;
    bit done;
    int w;
    nl   = 0;
    done = 0;
    if (mdl_owner < 0) begin
      w = pick_winner();
      for (int i = 0; i < N; i++) begin
        if (!is_req(i))  mdl_age[i] = 0;
        else if (i == w) mdl_age[i] = 0;
        else             mdl_age[i] = (mdl_age[i] + 1 > AL) ? AL : mdl_age[i] + 1;
      end
      if (w >= 0) begin
        mdl_owner = w;
        mdl_wd    = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) if (!is_req(i)) mdl_age[i] = 0;
      if (!s_wb_cyc[mdl_owner]) done = 1;
      else if (m_wb_ack) begin
        mdl_wd = 0;
        if (s_tag[mdl_owner].eop) done = 1;
      end else if (mdl_wd == LT - 1) begin
        done = 1;
        nl   = 1;
      end else mdl_wd++;
      if (done) begin
        mdl_rr    = (mdl_owner + 1) % N;
        mdl_owner = -1;
      end
    end
    mdl_lerr = nl;
  endtask

  function automatic logic [71:0] model_out();
    logic [N-1:0] g, a;
    logic c, s, w;
    logic [15:0] ad;
    logic [31:0] d;
    logic [3:0] se;
    mailbox_tag_t t;
    g = '0; a = '0; c = 0; s = 0; w = 0; ad = '0; d = '0; se = '0; t = '0;
    if (mdl_owner >= 0) begin
      g[mdl_owner] = 1'b1;
      c  = s_wb_cyc[mdl_owner];
      s  = s_wb_stb[mdl_owner];
      w  = s_wb_we[mdl_owner];
      ad = s_wb_adr[mdl_owner];
      d  = s_wb_dat[mdl_owner];
      se = s_wb_sel[mdl_owner];
      t  = s_tag[mdl_owner];
      if (c) a[mdl_owner] = m_wb_ack;
    end
    return {g, a, c, s, w, ad, d, se, t, mdl_lerr};
  endfunction

  function automatic logic [71:0] dut_out();
    return {grant_oh, s_wb_ack, m_wb_cyc, m_wb_stb, m_wb_we, m_wb_adr,
            m_wb_dat, m_wb_sel, m_tag, lock_err};
  endfunction

  task automatic drive(input logic [N-1:0] rq, input logic [N-1:0] pr,
                       input logic [N-1:0] eo, input bit ackon);
    for (int i = 0; i < N; i++) begin
      s_wb_cyc[i]    = rq[i];
      s_wb_stb[i]    = rq[i];
      s_wb_we[i]     = 1'($urandom);
      s_wb_adr[i]    = 16'($urandom);
      s_wb_dat[i]    = $urandom;
      s_wb_sel[i]    = 4'($urandom);
      s_tag[i].chan  = 6'($urandom);
      s_tag[i].prio  = pr[i];
      s_tag[i].eop   = eo[i];
    end
    m_wb_ack = 1'b0;
    if (ackon && mdl_owner >= 0) m_wb_ack = s_wb_stb[mdl_owner];
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive('0, '0, '0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    drive('1, '1, '1, 0);
    m_wb_ack = 1'b1;
    #1;
    if (dut_out() !== 72'h0) begin
      $display("FAIL reset_hold got=%h exp=%h", dut_out(), 72'h0); failures++;
    end
    checks++;
    @(posedge clk); #1;
    if (dut_out() !== 72'h0) begin
      $display("FAIL reset_edge got=%h exp=%h", dut_out(), 72'h0); failures++;
    end
    checks++;
    @(negedge clk);
    drive('0, '0, '0, 0);
    rst_n = 1'b1;
    #1;
    if (dut_out() !== model_out()) begin
      $display("FAIL reset_release got=%h exp=%h", dut_out(), model_out()); failures++;
    end
    checks++;
    advance();
  endtask

  task automatic test_single();
    bit done;
    done = 0;
    do_reset();
    for (int cy = 0; cy < 4; cy++) begin
      drive(done ? 4'b0000 : 4'b0001, 4'b0000, 4'b1111, 1);
      #1;
      if (dut_out() !== model_out()) begin
        $display("FAIL single cy=%0d got=%h exp=%h", cy, dut_out(), model_out()); failures++;
      end
      checks++;
      if (cy == 1 && {grant_oh, s_wb_ack} !== 8'h11) begin
        $display("FAIL single_grant got=%h exp=%h", {grant_oh, s_wb_ack}, 8'h11); failures++;
      end
      if (cy == 1) checks++;
      if (mdl_owner == 0 && m_wb_ack) done = 1;
      advance();
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g [10];
    exp_g = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
    do_reset();
    for (int cy = 0; cy < 10; cy++) begin
      drive(4'b1111, 4'b0000, 4'b1111, 1);
      #1;
      if (dut_out() !== model_out()) begin
        $display("FAIL rr_model cy=%0d got=%h exp=%h", cy, dut_out(), model_out()); failures++;
      end
      if (grant_oh !== exp_g[cy]) begin
        $display("FAIL rr_order cy=%0d got=%h exp=%h", cy, grant_oh, exp_g[cy]); failures++;
      end
      checks += 2;
      advance();
    end
  endtask

  task automatic test_priority();
    logic [N-1:0] exp_g [6];
    logic [N-1:0] done;
    exp_g = '{4'h0, 4'h4, 4'h0, 4'h2, 4'h0, 4'h0};
    done  = '0;
    do_reset();
    for (int cy = 0; cy < 6; cy++) begin
      drive(4'b0110 & ~done, 4'b0100, 4'b1111, 1);
      #1;
      if (dut_out() !== model_out()) begin
        $display("FAIL prio_model cy=%0d got=%h exp=%h", cy, dut_out(), model_out()); failures++;
      end
      if (grant_oh !== exp_g[cy]) begin
        $display("FAIL prio_order cy=%0d got=%h exp=%h", cy, grant_oh, exp_g[cy]); failures++;
      end
      checks += 2;
      if (mdl_owner >= 0 && m_wb_ack) done[mdl_owner] = 1'b1;
      advance();
    end
  endtask

  task automatic test_packet_lock();
    logic [N-1:0] exp_g [7];
    int beats;
    bit done0, done3;
    exp_g = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h8, 4'h0};
    beats = 0; done0 = 0; done3 = 0;
    do_reset();
    for (int cy = 0; cy < 7; cy++) begin
      drive({!done3, 2'b00, !done0}, 4'b0000, {1'b1, 2'b00, beats == 2}, 1);
      #1;
      if (dut_out() !== model_out()) begin
        $display("FAIL lock_model cy=%0d got=%h exp=%h", cy, dut_out(), model_out()); failures++;
      end
      if (grant_oh !== exp_g[cy]) begin
        $display("FAIL lock_order cy=%0d got=%h exp=%h", cy, grant_oh, exp_g[cy]); failures++;
      end
      checks += 2;
      if (mdl_owner == 0 && m_wb_ack) begin
        beats++;
        if (beats == 3) done0 = 1;
      end
      if (mdl_owner == 3 && m_wb_ack) done3 = 1;
      advance();
    end
  endtask

  task automatic test_starvation();
    logic [N-1:0] exp_g [6];
    bit done0;
    exp_g = '{4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h1};
    done0 = 0;
    do_reset();
    for (int cy = 0; cy < 6; cy++) begin
      drive({2'b01, 1'b1, !done0}, 4'b0110, 4'b1111, 1);
      #1;
      if (dut_out() !== model_out()) begin
        $display("FAIL starve_model cy=%0d got=%h exp=%h", cy, dut_out(), model_out()); failures++;
      end
      if (grant_oh !== exp_g[cy]) begin
        $display("FAIL starve_order cy=%0d got=%h exp=%h", cy, grant_oh, exp_g[cy]); failures++;
      end
      checks += 2;
      if (mdl_owner == 0 && m_wb_ack) done0 = 1;
      advance();
    end
  endtask

  task automatic test_watchdog();
    int pulses;
    pulses = 0;
    do_reset();
    for (int cy = 0; cy < 12; cy++) begin
      drive((cy < 9) ? 4'b0100 : 4'b0000, 4'b0000, 4'b0000, 0);
      #1;
      if (dut_out() !== model_out()) begin
        $display("FAIL wd_model cy=%0d got=%h exp=%h", cy, dut_out(), model_out()); failures++;
      end
      if (grant_oh !== ((cy >= 1 && cy <= 8) ? 4'h4 : 4'h0)) begin
        $display("FAIL wd_grant cy=%0d got=%h exp=%h", cy, grant_oh,
                 (cy >= 1 && cy <= 8) ? 4'h4 : 4'h0); failures++;
      end
      if (lock_err !== (cy == 9)) begin
        $display("FAIL wd_lock_err cy=%0d got=%b exp=%b", cy, lock_err, cy == 9); failures++;
      end
      checks += 3;
      if (lock_err === 1'b1) pulses++;
      advance();
    end
    if (pulses != 1) begin
      $display("FAIL wd_pulse_count got=%0d exp=1", pulses); failures++;
    end
    checks++;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    for (int cy = 0; cy < 3; cy++) begin
      drive(4'b0010, 4'b0000, 4'b0000, 1);
      #1;
      if (dut_out() !== model_out()) begin
        $display("FAIL midrst_pre cy=%0d got=%h exp=%h", cy, dut_out(), model_out()); failures++;
      end
      checks++;
      if (cy < 2) advance();
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    if (dut_out() !== 72'h0) begin
      $display("FAIL midrst_async got=%h exp=%h", dut_out(), 72'h0); failures++;
    end
    checks++;
    @(posedge clk); #1;
    if (dut_out() !== 72'h0) begin
      $display("FAIL midrst_hold got=%h exp=%h", dut_out(), 72'h0); failures++;
    end
    checks++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int cy = 0; cy < 4; cy++) begin
      drive(4'b0010, 4'b0000, 4'b1111, 0);
      #1;
      if (dut_out() !== model_out()) begin
        $display("FAIL midrst_post cy=%0d got=%h exp=%h", cy, dut_out(), model_out()); failures++;
      end
      checks++;
      advance();
    end
  endtask

  task automatic test_random();
    logic [N-1:0] hold;
    bit stall;
    hold = '0;
    do_reset();
    for (int cy = 0; cy < 3000; cy++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(9) == 0) hold[i] = ~hold[i];
        s_wb_cyc[i]   = hold[i];
        s_wb_stb[i]   = hold[i] && ($urandom_range(3) != 0);
        s_wb_we[i]    = 1'($urandom);
        s_wb_adr[i]   = 16'($urandom);
        s_wb_dat[i]   = $urandom;
        s_wb_sel[i]   = 4'($urandom);
        s_tag[i].chan = 6'($urandom);
        s_tag[i].prio = 1'($urandom);
        s_tag[i].eop  = ($urandom_range(2) == 0);
      end
      stall    = (cy % 500) < 20;
      m_wb_ack = 1'b0;
      if (mdl_owner >= 0 && !stall && s_wb_stb[mdl_owner] && $urandom_range(2) != 0)
        m_wb_ack = 1'b1;
      #1;
      if (dut_out() !== model_out()) begin
        $display("FAIL random cy=%0d got=%h exp=%h", cy, dut_out(), model_out()); failures++;
      end
      checks++;
      advance();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    drive('0, '0, '0, 0);
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_packet_lock();
    test_starvation();
    test_watchdog();
    test_reset_mid_packet();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
